multicycle_control_sequencer: RTL



---
 rtl/multicycle_control_sequencer_if.sv | 46 ++++
 rtl/multicycle_control_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_sequencer_if
// Purpose  : Bundles the opcode / memory-ready inputs and every control strobe
//            exchanged between the multicycle control sequencer and the
//            datapath it drives.
// Modports : master - the sequencer (consumes opcode/mem_ready, drives controls)
//            slave  - the datapath side (drives opcode/mem_ready, sees controls)
// Signals  : opcode[3:0], mem_ready, jump, beq, bne, call, ret, mem_read,
//            mem_write, alu_src, reg_dst, mem_to_reg, reg_write, alu_op[1:0],
//            state[2:0], instr_done, halted, fault
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_sequencer_if;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       jump;
  logic       beq;
  logic       bne;
  logic       call;
  logic       ret;
  logic       mem_read;
  logic       mem_write;
  logic       alu_src;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic       instr_done;
  logic       halted;
  logic       fault;

  modport master (
    input  opcode, mem_ready,
    output jump, beq, bne, call, ret, mem_read, mem_write, alu_src, reg_dst,
           mem_to_reg, reg_write, alu_op, state, instr_done, halted, fault
  );

  modport slave (
    output opcode, mem_ready,
    input  jump, beq, bne, call, ret, mem_read, mem_write, alu_src, reg_dst,
           mem_to_reg, reg_write, alu_op, state, instr_done, halted, fault
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_sequencer
// Purpose  : Multi-cycle control FSM feeding Datapath_Unit. Steps each
//            instruction through FETCH/DECODE/EXEC/MEM/WB, stalls in MEM on
//            mem_ready, and (optionally) tracks subroutine call depth.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - multicycle_control_sequencer_if.master (opcode/mem_ready
//                    in, all control strobes, state, instr_done, halted, fault)
// Params   : CALL_DEPTH - maximum outstanding CALL nesting (1..255)
// Macro    : CALL_DEPTH_CHECK_EN - when defined, builds the call-depth counter;
//            CALL beyond CALL_DEPTH or RET at depth 0 sets sticky fault and
//            halts. When undefined, fault is tied low and call/ret always issue.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_sequencer #(
  parameter int unsigned CALL_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  multicycle_control_sequencer_if.master       bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] c_op_halt = 4'h7;
  localparam logic [3:0] c_op_lw   = 4'h8;
  localparam logic [3:0] c_op_sw   = 4'h9;
  localparam logic [3:0] c_op_addi = 4'hA;
  localparam logic [3:0] c_op_beq  = 4'hB;
  localparam logic [3:0] c_op_bne  = 4'hC;
  localparam logic [3:0] c_op_jmp  = 4'hD;
  localparam logic [3:0] c_op_call = 4'hE;
  localparam logic [3:0] c_op_ret  = 4'hF;

  // Out-of-range depth is a configuration error caught at elaboration.
  if (CALL_DEPTH < 1 || CALL_DEPTH > 255) begin : g_call_depth_range_err
    $error("CALL_DEPTH must be in 1..255");
  end

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_ir_op;

  // Instruction class decode, always from the latched opcode.
  logic w_is_rtype;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_addi;
  logic w_is_beq;
  logic w_is_bne;
  logic w_is_jmp;
  logic w_is_call;
  logic w_is_ret;
  logic w_is_halt;
  logic w_is_ctrl;

  assign w_is_rtype = (r_ir_op < c_op_halt);
  assign w_is_halt  = (r_ir_op == c_op_halt);
  assign w_is_lw    = (r_ir_op == c_op_lw);
  assign w_is_sw    = (r_ir_op == c_op_sw);
  assign w_is_addi  = (r_ir_op == c_op_addi);
  assign w_is_beq   = (r_ir_op == c_op_beq);
  assign w_is_bne   = (r_ir_op == c_op_bne);
  assign w_is_jmp   = (r_ir_op == c_op_jmp);
  assign w_is_call  = (r_ir_op == c_op_call);
  assign w_is_ret   = (r_ir_op == c_op_ret);
  assign w_is_ctrl  = w_is_beq | w_is_bne | w_is_jmp | w_is_call | w_is_ret;

  // High in EXEC when a CALL/RET would violate the nesting bound.
  logic w_trip;

`ifdef CALL_DEPTH_CHECK_EN
  localparam logic [7:0] c_call_depth = 8'(CALL_DEPTH);

  logic [7:0] r_depth;
  logic       r_fault;

  assign w_trip = (r_state == S_EXEC) &&
                  ((w_is_call && (r_depth == c_call_depth)) ||
                   (w_is_ret  && (r_depth == 8'd0)));

  // Depth saturates at both ends; a tripped CALL/RET leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth <= 8'd0;
      r_fault <= 1'b0;
    end else if (r_state == S_EXEC) begin
      if (w_trip) begin
        r_fault <= 1'b1;
      end else if (w_is_call && (r_depth != 8'hFF)) begin
        r_depth <= r_depth + 8'd1;
      end else if (w_is_ret && (r_depth != 8'd0)) begin
        r_depth <= r_depth - 8'd1;
      end
    end
  end

  assign bus.fault = r_fault;
`else
  assign w_trip    = 1'b0;
  assign bus.fault = 1'b0;
`endif

  // State register and instruction latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_ir_op <= 4'h0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FETCH) begin
        r_ir_op <= bus.opcode;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: w_next_state = w_is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_is_lw || w_is_sw) begin
          w_next_state = S_MEM;
        end else if (w_is_ctrl) begin
          w_next_state = w_trip ? S_HALT : S_FETCH;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          w_next_state = w_is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB:     w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Control outputs. Everything derives from state and ir_op, except the
  // SW completion flag, which must mark the exact MEM cycle that mem_ready
  // ends and therefore is gated by it.
  logic       w_jump;
  logic       w_beq;
  logic       w_bne;
  logic       w_call;
  logic       w_ret;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_alu_src;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic [1:0] w_alu_op;
  logic       w_instr_done;
  logic [1:0] w_alu_cls;

  always_comb begin
    w_jump       = 1'b0;
    w_beq        = 1'b0;
    w_bne        = 1'b0;
    w_call       = 1'b0;
    w_ret        = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_op     = 2'b00;
    w_instr_done = 1'b0;

    if (w_is_rtype) begin
      w_alu_cls = 2'b10;
    end else if (w_is_beq || w_is_bne) begin
      w_alu_cls = 2'b01;
    end else begin
      w_alu_cls = 2'b00;
    end

    case (r_state)
      S_EXEC: begin
        w_alu_op     = w_alu_cls;
        w_alu_src    = w_is_lw | w_is_sw | w_is_addi;
        w_beq        = w_is_beq;
        w_bne        = w_is_bne;
        w_jump       = w_is_jmp;
        w_call       = w_is_call & ~w_trip;
        w_ret        = w_is_ret  & ~w_trip;
        w_instr_done = w_is_ctrl & ~w_trip;
      end
      S_MEM: begin
        w_alu_op     = w_alu_cls;
        w_alu_src    = w_is_lw | w_is_sw | w_is_addi;
        w_mem_read   = w_is_lw;
        w_mem_write  = w_is_sw;
        w_instr_done = w_is_sw & bus.mem_ready;
      end
      S_WB: begin
        w_alu_op     = w_alu_cls;
        w_alu_src    = w_is_lw | w_is_sw | w_is_addi;
        w_reg_write  = 1'b1;
        w_reg_dst    = w_is_rtype;
        w_mem_to_reg = w_is_lw;
        w_mem_read   = w_is_lw;
        w_instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.jump       = w_jump;
  assign bus.beq        = w_beq;
  assign bus.bne        = w_bne;
  assign bus.call       = w_call;
  assign bus.ret        = w_ret;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.alu_src    = w_alu_src;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.reg_write  = w_reg_write;
  assign bus.alu_op     = w_alu_op;
  assign bus.state      = r_state;
  assign bus.instr_done = w_instr_done;
  assign bus.halted     = (r_state == S_HALT);

endmodule
`default_nettype wire
